// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared reorder-buffer sizing, entry-type encodings and entry payload layout.
package rob_commit_pkg;
  localparam int ROB_SIZE_WIDTH = 3;
  localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
  typedef enum logic [1:0] {
    T_ALU    = 2'b00,
    T_BRANCH = 2'b01,
    T_STORE  = 2'b10,
    T_EXIT   = 2'b11
  } rob_type_e;
  typedef struct packed {
    rob_type_e   kind;
    logic [4:0]  rd;
    logic        pred_jump;
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } rob_entry_t;
endpackage

// File: rtl/rob_query_port.sv
// rob_query_port: one operand-forwarding lookup (entry select plus optional same-cycle writeback compare).
module rob_query_port
  import rob_commit_pkg::*;
(
  input  logic [ROB_SIZE_WIDTH-1:0] ask_id,
  input  logic [ROB_SIZE-1:0]       busy,
  input  logic [ROB_SIZE-1:0]       ready,
  input  logic [31:0]               value [ROB_SIZE],
  input  logic                      alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
  input  logic [31:0]               alu_value,
  input  logic                      lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
  input  logic [31:0]               lsb_value,
  output logic [31:0]               get_value,
  output logic                      get_ready
);
  logic alu_hit, lsb_hit;
  always_comb begin
    alu_hit   = alu_valid && alu_id == ask_id && busy[ask_id];
    lsb_hit   = lsb_valid && lsb_id == ask_id && busy[ask_id];
    get_ready = busy[ask_id] && (ready[ask_id] || alu_hit || lsb_hit);
    get_value = alu_hit ? alu_value : lsb_hit ? lsb_value : value[ask_id];
  end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with single-width retire and mispredict flush.
// ROB_WB_BYPASS_EN: forwarding queries also see same-cycle writeback buses (ALU over LSB).
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [1:0]                issue_type,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_pred_jump,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic                      wb_alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] wb_alu_rob_id,
  input  logic [31:0]               wb_alu_value,
  input  logic                      wb_alu_jump,
  input  logic [31:0]               wb_alu_target,
  input  logic                      wb_lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] wb_lsb_rob_id,
  input  logic [31:0]               wb_lsb_value,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
  output logic [31:0]               get_value1,
  output logic [31:0]               get_value2,
  output logic                      get_ready1,
  output logic                      get_ready2,
  output logic                      commit_en,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic                      commit_store,
  output logic                      rob_clear,
  output logic [31:0]               back_pc,
  output logic                      halt
);
`ifdef ROB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam int W = ROB_SIZE_WIDTH;
  logic [W-1:0]        head, tail;
  logic [W:0]          count;
  logic [ROB_SIZE-1:0] busy, ready;
  rob_entry_t          ent [ROB_SIZE];
  logic [31:0]         val_arr [ROB_SIZE];
  rob_entry_t          head_e;
  logic                issue_acc, fire, mispredict, byp_alu, byp_lsb;
  assign rob_full     = count == (W+1)'(ROB_SIZE);
  assign issue_rob_id = tail;
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) val_arr[i] = ent[i].value;
    head_e     = ent[head];
    issue_acc  = issue_valid && !rob_full && !rob_clear;
    fire       = count != '0 && busy[head] && ready[head] && !halt;
    mispredict = fire && head_e.kind == T_BRANCH && head_e.jump != head_e.pred_jump;
    byp_alu    = BYP && rdy && !rob_clear && wb_alu_valid;
    byp_lsb    = BYP && rdy && !rob_clear && wb_lsb_valid;
  end
  rob_query_port u_q1 (
    .ask_id(ask_rob_id1), .busy(busy), .ready(ready), .value(val_arr),
    .alu_valid(byp_alu), .alu_id(wb_alu_rob_id), .alu_value(wb_alu_value),
    .lsb_valid(byp_lsb), .lsb_id(wb_lsb_rob_id), .lsb_value(wb_lsb_value),
    .get_value(get_value1), .get_ready(get_ready1)
  );
  rob_query_port u_q2 (
    .ask_id(ask_rob_id2), .busy(busy), .ready(ready), .value(val_arr),
    .alu_valid(byp_alu), .alu_id(wb_alu_rob_id), .alu_value(wb_alu_value),
    .lsb_valid(byp_lsb), .lsb_id(wb_lsb_rob_id), .lsb_value(wb_lsb_value),
    .get_value(get_value2), .get_ready(get_ready2)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      ready         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
      commit_en     <= 1'b0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_store  <= 1'b0;
      rob_clear     <= 1'b0;
      back_pc       <= '0;
      halt          <= 1'b0;
    end else if (rdy) begin
      commit_en     <= fire;
      commit_rob_id <= fire ? head : '0;
      commit_rd     <= fire && (head_e.kind == T_ALU || head_e.kind == T_BRANCH) ? head_e.rd : '0;
      commit_value  <= fire ? head_e.value : '0;
      commit_store  <= fire && head_e.kind == T_STORE;
      rob_clear     <= mispredict;
      back_pc       <= mispredict ? head_e.target : '0;
      if (fire && head_e.kind == T_EXIT) halt <= 1'b1;
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        // writebacks are qualified on the pre-edge busy bit, so a write aimed at the slot being issued is ignored
        if (!rob_clear && wb_alu_valid && busy[wb_alu_rob_id]) begin
          ready[wb_alu_rob_id]        <= 1'b1;
          ent[wb_alu_rob_id].value    <= wb_alu_value;
          ent[wb_alu_rob_id].jump     <= wb_alu_jump;
          ent[wb_alu_rob_id].target   <= wb_alu_target;
        end
        if (!rob_clear && wb_lsb_valid && busy[wb_lsb_rob_id]) begin
          ready[wb_lsb_rob_id]        <= 1'b1;
          ent[wb_lsb_rob_id].value    <= wb_lsb_value;
        end
        if (issue_acc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          ent[tail]   <= '{rob_type_e'(issue_type), issue_rd, issue_pred_jump, 32'h0, 1'b0, 32'h0};
          tail        <= tail + 1'b1;
        end
        if (fire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        count <= count + {{W{1'b0}}, issue_acc} - {{W{1'b0}}, fire};
      end
    end
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer that produces the commit stream consumed by the register file's commit port (`commit_rob_id`/`commit_rd`/`commit_value`) and the pipeline-wide clear (`rob_clear`/`back_pc`). It sits between decoder/issue, the ALU/LSB writeback buses and the register file. It allocates RoB ids in program order, collects results, retires one instruction per cycle in order and flushes the machine on branch mispredict. It also answers the register file's operand-forwarding queries (`ask_rob_id*` → `get_value*`/`get_ready*`).

## Interface
- `ROB_SIZE_WIDTH`, 3: log2 of entry count (8 entries).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, **asynchronous, active-low**.
- `rdy`  in  1  when low, freeze all state; outputs hold.
- `issue_valid`  in  1  allocate an entry this cycle.
- `issue_type`  in  2  00 ALU, 01 BRANCH, 10 STORE, 11 EXIT.
- `issue_rd`  in  5  destination register; 0 means no write.
- `issue_pred_jump`  in  1  predicted taken (BRANCH only).
- `rob_full`  out  1  no free entry.
- `issue_rob_id`  out  W  id the next accepted issue receives (tail).
- `wb_alu_valid`, `wb_alu_rob_id`[W], `wb_alu_value`[32], `wb_alu_jump`[1], `wb_alu_target`[32]  in  ALU/branch result.
- `wb_lsb_valid`, `wb_lsb_rob_id`[W], `wb_lsb_value`[32]  in  load result / store-address-ready.
- `ask_rob_id1`, `ask_rob_id2`  in  W  forwarding query ids.
- `get_value1/2`  out  32, `get_ready1/2`  out  1  combinational query answers.
- `commit_en`  out  1  commit outputs valid.
- `commit_rob_id`  out  W, `commit_rd`  out  5, `commit_value`  out  32.
- `commit_store`  out  1  head STORE retired; LSB may perform it.
- `rob_clear`  out  1  one-cycle flush pulse.
- `back_pc`  out  32  redirect PC, valid with `rob_clear`.
- `halt`  out  1  sticky after EXIT commits.

## Operation
- Circular buffer, `head`, `tail` (W bits), `count` (W+1 bits). Entry: busy, ready, type, rd, pred_jump, value, jump, target.
- Issue: accepted iff `issue_valid && !rob_full && !rob_clear`; entry at tail gets busy=1, ready=0; tail wraps 2^W−1 → 0.
- Writeback: each valid port sets ready=1 and stores value (ALU port also jump/target) in the addressed entry. Both ports to different ids in one cycle both land; same id is illegal. Writes to non-busy entries are ignored.
- Commit: if count≠0 and head entry ready: pop head, free entry, drive commit outputs. `commit_rd` is forced to 0 for STORE/EXIT. BRANCH retains its rd (JALR link, value = pc+4 from ALU).
- Mispredict: committing BRANCH with jump≠pred_jump → `rob_clear`=1, `back_pc`=target; same edge resets head=tail=count=0 and clears all busy bits. Issue and writeback presented during the `rob_clear` cycle are dropped.
- EXIT commit sets `halt`; no further commits.
- `rob_full` = (count == 2^W), from registered count; issue+commit in the same cycle while full: commit happens, issue refused.
- Query: `get_ready` = busy && ready of addressed entry; `get_value` = its value.

## Timing
- Reset (rst_n low, async): all outputs 0, head/tail/count 0, all entries idle, halt 0.
- Issue at edge t → entry busy after t; `issue_rob_id` advances after t.
- Writeback at edge t → earliest commit edge t+1; commit outputs registered, visible after that edge for one cycle (`commit_en`, `commit_store`, `rob_clear` are one-cycle pulses).
- Throughput: 1 issue and 1 commit per cycle.
- `rdy` low: no state change, pulses held unchanged; resume exactly where frozen.

## Configuration
- `ROB_WB_BYPASS_EN` defined: query answers also match same-cycle writeback ports (ALU priority over LSB), so `get_ready`=1 with the bus value in the writeback cycle.
- Undefined: query reflects stored entry state only; writeback visible one cycle later.

## Structure
- Shared config header: `ROB_SIZE_WIDTH`, entry-type encodings (ALU/BRANCH/STORE/EXIT).
- One sub-module `rob_query_port` (one instance per query: entry select + bypass compare), instantiated twice.

## Test plan
- Reset, issue ALU rd=5; ALU wb id0 value 0x1234 → next cycle `commit_en`=1, rd=5, value 0x1234, rob_id 0.
- Issue 8 entries without wb → `rob_full`=1, 9th issue refused; wb id0 → commit, then issue accepted, id wraps to 0.
- Issue ids 0,1; wb id1 then id0 → commits strictly in order 0 then 1.
- BRANCH pred 0, wb jump=1 target 0x100 → `rob_clear`=1, `back_pc`=0x100, count 0, `issue_rob_id`=0.
- Query id2 in wb cycle: with `ROB_WB_BYPASS_EN` ready=1 same cycle; without, next cycle.
- `rdy` low for 3 cycles mid-commit → outputs held, no extra commits; assert rst_n low mid-stream → all outputs 0 immediately.
